// File: rtl/reflet_ram_dual_port_clr_if.sv
// reflet_ram_dual_port_clr_if: user-side bus of the clearable dual-port RAM.
interface reflet_ram_dual_port_clr_if #(
  parameter int addrSize = 7,
  parameter int depth    = 16,
  parameter int lanes    = 2
);
  logic                enable;
  logic                clear;
  logic [addrSize-1:0] addr_read;
  logic [addrSize-1:0] addr_write;
  logic [depth-1:0]    data_in;
  logic                write_en;
  logic [lanes-1:0]    write_mask;
  logic [depth-1:0]    data_out;
  logic                read_valid;
  logic                busy;
  modport master (
    output enable, clear, addr_read, addr_write, data_in, write_en, write_mask,
    input  data_out, read_valid, busy
  );
  modport slave (
    input  enable, clear, addr_read, addr_write, data_in, write_en, write_mask,
    output data_out, read_valid, busy
  );
endinterface

// File: rtl/reflet_ram_dual_port_clr.sv
// reflet_ram_dual_port_clr: lane-masked 1W/1R RAM with RDW policy and sequential clear sweep.
// Define REFLET_RAM_OUTPUT_REG_EN to add an output pipeline stage (read latency 2).
module reflet_ram_dual_port_clr #(
  parameter int               addrSize   = 7,
  parameter int               size       = 128,
  parameter int               depth      = 16,
  parameter int               laneWidth  = 8,
  parameter int               readNew    = 0,
  parameter logic [depth-1:0] clearValue = '0
) (
  input logic                       clk,
  input logic                       rst_n,
  reflet_ram_dual_port_clr_if.slave bus
);
  localparam int lanes = depth / laneWidth;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t              state_q;
  logic [addrSize-1:0] cnt_q;
  logic                busy_q;
  logic [depth-1:0]    mem_q [size];
  logic [depth-1:0]    old_w, new_w, rdata_d, rdata_q;
  logic                rd_acc, rd_ok, wr_acc, rv_q;
  assign rd_acc  = bus.enable && !busy_q;
  assign rd_ok   = 32'(bus.addr_read) < size;
  assign wr_acc  = bus.enable && bus.write_en && !busy_q && !bus.clear && 32'(bus.addr_write) < size;
  assign old_w   = rd_ok ? mem_q[bus.addr_read] : '0;
  always_comb begin
    new_w = old_w;
    for (int k = 0; k < lanes; k++)
      new_w[k*laneWidth +: laneWidth] = bus.write_mask[k] ? bus.data_in[k*laneWidth +: laneWidth]
                                                          : old_w[k*laneWidth +: laneWidth];
  end
  // a same-address accepted write implies the read address is in range
  assign rdata_d = !rd_acc ? '0 :
                   (readNew != 0 && wr_acc && bus.addr_write == bus.addr_read) ? new_w : old_w;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (state_q == CLEAR) begin
      cnt_q <= bus.clear ? '0 : cnt_q + 1'b1;
      if (!bus.clear && 32'(cnt_q) == size - 1) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end else if (bus.clear) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end
  end
  // array has no reset so it can map onto block RAM
  always_ff @(posedge clk) begin
    if (busy_q)
      mem_q[cnt_q] <= clearValue;
    else if (wr_acc)
      for (int k = 0; k < lanes; k++)
        if (bus.write_mask[k])
          mem_q[bus.addr_write][k*laneWidth +: laneWidth] <= bus.data_in[k*laneWidth +: laneWidth];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rv_q    <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rv_q    <= rd_acc;
    end
  end
`ifdef REFLET_RAM_OUTPUT_REG_EN
  logic [depth-1:0] rdata2_q;
  logic             rv2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata2_q <= '0;
      rv2_q    <= 1'b0;
    end else begin
      rdata2_q <= rdata_q;
      rv2_q    <= rv_q;
    end
  end
  assign bus.data_out   = rdata2_q;
  assign bus.read_valid = rv2_q;
`else
  assign bus.data_out   = rdata_q;
  assign bus.read_valid = rv_q;
`endif
  assign bus.busy = busy_q;
endmodule
